// File: rtl/ins_fetch_q_if.sv
// I-cache, branch-resolve, predictor and decoder-side signals of the queued instruction fetcher.
// The master modport is the fetcher; the slave modport is its surroundings.
interface ins_fetch_q_if #(
    parameter int QDEPTH = 4
);
    logic                      ic_req_o;
    logic [31:0]               ic_pc_o;
    logic                      ic_vld_i;
    logic [31:0]               ic_ins_i;

    logic                      br_flag_i;
    logic                      br_abr_i;
    logic [31:0]               br_tpc_i;
    logic [31:0]               br_cbt_i;

    logic [31:0]               bp_pc_o;
    logic                      bp_br_i;
    logic                      bp_en_o;
    logic                      bp_abr_o;
    logic [31:0]               bp_tpc_o;

    logic                      is_vld_o;
    logic                      is_rdy_i;
    logic [31:0]               is_ins_o;
    logic [31:0]               is_pc_o;
    logic                      is_ic_o;
    logic                      is_pbr_o;
    logic [$clog2(QDEPTH):0]   q_cnt_o;

    modport master (
        output ic_req_o, ic_pc_o,
        input  ic_vld_i, ic_ins_i,
        input  br_flag_i, br_abr_i, br_tpc_i, br_cbt_i,
        output bp_pc_o, bp_en_o, bp_abr_o, bp_tpc_o,
        input  bp_br_i,
        output is_vld_o, is_ins_o, is_pc_o, is_ic_o, is_pbr_o, q_cnt_o,
        input  is_rdy_i
    );

    modport slave (
        input  ic_req_o, ic_pc_o,
        output ic_vld_i, ic_ins_i,
        output br_flag_i, br_abr_i, br_tpc_i, br_cbt_i,
        input  bp_pc_o, bp_en_o, bp_abr_o, bp_tpc_o,
        output bp_br_i,
        input  is_vld_o, is_ins_o, is_pc_o, is_ic_o, is_pbr_o, q_cnt_o,
        output is_rdy_i
    );
endinterface

// File: rtl/ins_fetch_q.sv
// Queued instruction fetcher: drives the I-cache, predecodes RV32I/RV32C control flow and
// buffers fetched instructions in a small FIFO ahead of the decoder.
module ins_fetch_q #(
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          ENABLE_C = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    ins_fetch_q_if.master     bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t          state;
    logic [31:0]     pc;
    logic [31:0]     drop_pc;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   cnt;

    logic [31:0]     q_ins [QDEPTH];
    logic [31:0]     q_pc  [QDEPTH];
    logic            q_ic  [QDEPTH];
    logic            q_pbr [QDEPTH];

    logic            req;
    logic            accept;
    logic            pop;
    logic            is_c;
    logic [31:0]     ins;
    logic [31:0]     ic_pc;
    logic [31:0]     next_pc;
    logic [31:0]     imm_cj, imm_cb, imm_j, imm_b;

    assign ins    = bus.ic_ins_i;
    assign ic_pc  = (state == DROP) ? drop_pc : pc;
    assign req    = en & ~rst & ((state != IDLE) | (cnt != FULL));
    assign accept = req & bus.ic_vld_i & (state != DROP) & ~bus.br_flag_i;
    assign pop    = en & bus.is_vld_o & bus.is_rdy_i;

    assign imm_cj = {{21{ins[12]}}, ins[8], ins[10:9], ins[6], ins[7], ins[2], ins[11], ins[5:3], 1'b0};
    assign imm_cb = {{24{ins[12]}}, ins[6:5], ins[2], ins[11:10], ins[4:3], 1'b0};
    assign imm_j  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    assign imm_b  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};

    // jalr, c.jr and c.jalr fall through to the sequential PC; the ROB redirects them.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        is_c    = (ENABLE_C != 0) && (ins[1:0] != 2'b11);
        next_pc = pc + (is_c ? 32'd2 : 32'd4);
        if (is_c) begin
            if (ins[1:0] == 2'b01 && ins[14:13] == 2'b01)
                next_pc = pc + imm_cj;
            else if (ins[1:0] == 2'b01 && ins[15:14] == 2'b11 && bus.bp_br_i)
                next_pc = pc + imm_cb;
        end else if (ins[6:0] == 7'b1101111) begin
            next_pc = pc + imm_j;
        end else if (ins[6:0] == 7'b1100011 && bus.bp_br_i) begin
            next_pc = pc + imm_b;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            drop_pc <= RESET_PC;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            cnt     <= '0;
        end else if (en) begin
            if (bus.br_flag_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
                pc     <= bus.br_cbt_i;
                case (state)
                    WAIT: begin
                        if (bus.ic_vld_i) begin
                            state <= IDLE;
                        end else begin
                            state   <= DROP;
                            drop_pc <= pc;
                        end
                    end
                    DROP:    if (bus.ic_vld_i) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end else begin
                if (accept) begin
                    pc     <= next_pc;
                    wr_ptr <= wr_ptr + 1'b1;
                    state  <= IDLE;
                end else if (state == DROP && bus.ic_vld_i) begin
                    state <= IDLE;
                end else if (state == IDLE && req && !bus.ic_vld_i) begin
                    state <= WAIT;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (accept != pop)
                    cnt <= accept ? cnt + 1'b1 : cnt - 1'b1;
            end
        end
    end

    // NOTE: FIFO storage has no reset; the count alone says which entries are meaningful.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_ins[wr_ptr] <= ins;
            q_pc[wr_ptr]  <= pc;
            q_ic[wr_ptr]  <= is_c;
            q_pbr[wr_ptr] <= bus.bp_br_i;
        end
    end

    assign bus.ic_req_o = req;
    assign bus.ic_pc_o  = ic_pc;
    assign bus.bp_pc_o  = ic_pc;
    assign bus.bp_en_o  = bus.br_flag_i;
    assign bus.bp_abr_o = bus.br_abr_i;
    assign bus.bp_tpc_o = bus.br_tpc_i;
    assign bus.is_vld_o = (cnt != '0);
    assign bus.is_ins_o = q_ins[rd_ptr];
    assign bus.is_pc_o  = q_pc[rd_ptr];
    assign bus.is_ic_o  = q_ic[rd_ptr];
    assign bus.is_pbr_o = q_pbr[rd_ptr];
    assign bus.q_cnt_o  = cnt;
endmodule

// File: tb/tb_ins_fetch_q.sv
// Bench for ins_fetch_q: directed scenarios plus random traffic, every cycle compared against
// a queue-based behavioural model of the fetcher.
module tb_ins_fetch_q;
    localparam int QD = 4;

    logic clk = 1'b0;
    logic rst;
    logic en;
    always #5 clk = ~clk;

    ins_fetch_q_if #(.QDEPTH(QD)) bus ();
    ins_fetch_q_if #(.QDEPTH(QD)) nbus ();

    ins_fetch_q #(.QDEPTH(QD), .RESET_PC(32'h0), .ENABLE_C(1)) dut (
        .clk(clk), .rst(rst), .en(en), .bus(bus)
    );
    ins_fetch_q #(.QDEPTH(QD), .RESET_PC(32'h0), .ENABLE_C(0)) dut_nc (
        .clk(clk), .rst(rst), .en(1'b1), .bus(nbus)
    );

    // Second instance: no C support, always hits, decoder always ready, fetches 16'h0001 words.
    assign nbus.ic_vld_i  = 1'b1;
    assign nbus.ic_ins_i  = 32'h0000_0001;
    assign nbus.br_flag_i = 1'b0;
    assign nbus.br_abr_i  = 1'b0;
    assign nbus.br_tpc_i  = 32'h0;
    assign nbus.br_cbt_i  = 32'h0;
    assign nbus.bp_br_i   = 1'b0;
    assign nbus.is_rdy_i  = 1'b1;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        ic;
        logic        pbr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc, m_drop;
    bit          m_busy, m_cancel, m_known;
    bit          use_prog;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Next PC from the ISA immediate definitions, built up arithmetically.
    function automatic logic [31:0] m_next(input logic [31:0] i, input logic [31:0] p, input logic bp);
        int off;
        if (i[1:0] != 2'b11) begin
            off = 2;
            if (i[1:0] == 2'b01 && (i[15:13] == 3'd1 || i[15:13] == 3'd5))
                off = (i[12] ? -2048 : 0) + 16 * int'(i[11]) + 256 * int'(i[10:9]) + 1024 * int'(i[8])
                    + 64 * int'(i[7]) + 128 * int'(i[6]) + 2 * int'(i[5:3]) + 32 * int'(i[2]);
            else if (i[1:0] == 2'b01 && i[15:13] >= 3'd6 && bp)
                off = (i[12] ? -256 : 0) + 8 * int'(i[11:10]) + 64 * int'(i[6:5])
                    + 2 * int'(i[4:3]) + 32 * int'(i[2]);
        end else begin
            off = 4;
            if (i[6:0] == 7'h6F)
                off = (i[31] ? -1048576 : 0) + 2 * int'(i[30:21]) + 2048 * int'(i[20]) + 4096 * int'(i[19:12]);
            else if (i[6:0] == 7'h63 && bp)
                off = (i[31] ? -4096 : 0) + 32 * int'(i[30:25]) + 2 * int'(i[11:8]) + 2048 * int'(i[7]);
        end
        return p + 32'(off);
    endfunction

    function automatic logic [31:0] prog(input logic [31:0] a);
        case (a)
            32'h08:  return 32'h0100_006F;  // jal x0, +0x10
            32'h18:  return 32'hDC75_0085;  // c.addi x1, 1
            32'h1A:  return 32'h0000_DC75;  // c.beqz x8, -4
            default: return 32'h0010_0093;  // addi x1, x0, 1
        endcase
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: r[6:0] = 7'h13;
            1: r[6:0] = 7'h6F;
            2: r[6:0] = 7'h63;
            3: r[6:0] = 7'h67;
            4: begin r[1:0] = 2'b01; r[15:13] = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5; end
            5: begin r[1:0] = 2'b01; r[15:13] = ($urandom_range(0, 1) != 0) ? 3'd6 : 3'd7; end
            6: begin r[1:0] = 2'b01; r[15:13] = 3'd0; end
            default: begin r[1:0] = 2'b10; r[15:12] = 4'b1000; end
        endcase
        return r;
    endfunction

    task automatic compare_model();
        logic        exp_req;
        logic [31:0] exp_pc;
        if (!m_known) return;
        exp_req = !rst && en && (m_busy || mq.size() < QD);
        exp_pc  = m_cancel ? m_drop : m_pc;
        check("ic_req", bus.ic_req_o, exp_req);
        check("ic_pc", bus.ic_pc_o, exp_pc);
        check("bp_pc", bus.bp_pc_o, exp_pc);
        check("bp_en", bus.bp_en_o, bus.br_flag_i);
        check("bp_abr", bus.bp_abr_o, bus.br_abr_i);
        check("bp_tpc", bus.bp_tpc_o, bus.br_tpc_i);
        check("q_cnt", bus.q_cnt_o, mq.size());
        check("is_vld", bus.is_vld_o, mq.size() != 0);
        if (mq.size() != 0) begin
            check("is_ins", bus.is_ins_o, mq[0].ins);
            check("is_pc", bus.is_pc_o, mq[0].pc);
            check("is_ic", bus.is_ic_o, mq[0].ic);
            check("is_pbr", bus.is_pbr_o, mq[0].pbr);
        end
    endtask

    task automatic model_step();
        bit   req;
        bit   vld;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_pc = 32'h0; m_drop = 32'h0; m_busy = 0; m_cancel = 0; m_known = 1;
            return;
        end
        if (!m_known || !en) return;
        req = m_busy || mq.size() < QD;
        vld = bus.ic_vld_i;
        if (bus.br_flag_i) begin
            mq.delete();
            if (m_busy && vld) begin
                m_busy = 0; m_cancel = 0;
            end else if (m_busy && !m_cancel) begin
                m_cancel = 1; m_drop = m_pc;
            end
            m_pc = bus.br_cbt_i;
        end else begin
            if (mq.size() != 0 && bus.is_rdy_i) void'(mq.pop_front());
            if (req && vld && !m_cancel) begin
                e = '{ins: bus.ic_ins_i, pc: m_pc, ic: bus.ic_ins_i[1:0] != 2'b11, pbr: bus.bp_br_i};
                mq.push_back(e);
                m_pc   = m_next(bus.ic_ins_i, m_pc, bus.bp_br_i);
                m_busy = 0;
            end else if (m_cancel && vld) begin
                m_busy = 0; m_cancel = 0;
            end else if (req && !vld) begin
                m_busy = 1;
            end
        end
    endtask

    // Called just after a falling edge with inputs driven; returns at the next falling edge.
    task automatic tick();
        #1;
        if (use_prog) begin
            bus.ic_ins_i = prog(bus.ic_pc_o);
            bus.bp_br_i  = (bus.ic_pc_o == 32'h1A);
            #1;
        end
        compare_model();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        en = 1'b1;
        bus.ic_vld_i = 1'b0; bus.ic_ins_i = 32'h0010_0093; bus.bp_br_i = 1'b0;
        bus.br_flag_i = 1'b0; bus.br_abr_i = 1'b0; bus.br_tpc_i = 32'h0; bus.br_cbt_i = 32'h0;
        bus.is_rdy_i = 1'b0;
        use_prog = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_in();
        tick();
        rst = 1'b0;
    endtask

    int          exp_pc_t2 [6] = '{32'h0, 32'h4, 32'h8, 32'h18, 32'h1A, 32'h16};
    bit          exp_ic_t2 [6] = '{0, 0, 0, 1, 1, 0};
    bit          exp_pb_t2 [6] = '{0, 0, 0, 0, 1, 0};
    logic [31:0] t;

    initial begin
        m_known = 0;
        rst = 1'b1;
        idle_in();
        tick();

        // Reset state, held in reset with en high.
        tick();
        check("rst_req", bus.ic_req_o, 1'b0);
        check("rst_cnt", bus.q_cnt_o, 0);
        check("rst_vld", bus.is_vld_o, 1'b0);
        check("rst_pc", bus.ic_pc_o, 32'h0);
        rst = 1'b0;

        // Straight-line 32-bit stream, one per cycle; C-less instance runs alongside.
        bus.ic_vld_i = 1'b1; bus.is_rdy_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t1_pc", bus.is_pc_o, 32'(4 * k));
            check("t1_ic", bus.is_ic_o, 1'b0);
            check("nc_pc", nbus.is_pc_o, 32'(4 * k));
            check("nc_ic", nbus.is_ic_o, 1'b0);
        end

        // jal, compressed instruction, predicted-taken c.beqz.
        do_reset();
        bus.ic_vld_i = 1'b1; bus.is_rdy_i = 1'b1; use_prog = 1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t2_pc", bus.is_pc_o, 32'(exp_pc_t2[k]));
            check("t2_ic", bus.is_ic_o, exp_ic_t2[k]);
            check("t2_pbr", bus.is_pbr_o, exp_pb_t2[k]);
        end
        use_prog = 0;

        // Stalled decoder fills the FIFO; one pop frees one slot.
        do_reset();
        bus.ic_vld_i = 1'b1;
        repeat (4) tick();
        check("t3_full_cnt", bus.q_cnt_o, 4);
        check("t3_full_req", bus.ic_req_o, 1'b0);
        bus.is_rdy_i = 1'b1;
        tick();
        check("t3_pop_cnt", bus.q_cnt_o, 3);
        check("t3_pop_req", bus.ic_req_o, 1'b1);
        bus.is_rdy_i = 1'b0;
        tick();
        check("t3_refill_cnt", bus.q_cnt_o, 4);

        // Redirect during a cache miss: stale response dropped.
        do_reset();
        bus.br_flag_i = 1'b1; bus.br_cbt_i = 32'h20;
        tick();
        bus.br_flag_i = 1'b0;
        tick();
        check("t4_wait_pc", bus.ic_pc_o, 32'h20);
        bus.br_flag_i = 1'b1; bus.br_cbt_i = 32'h100;
        tick();
        bus.br_flag_i = 1'b0;
        check("t4_drop_pc", bus.ic_pc_o, 32'h20);
        check("t4_drop_req", bus.ic_req_o, 1'b1);
        tick();
        bus.ic_vld_i = 1'b1;
        tick();
        check("t4_stale_cnt", bus.q_cnt_o, 0);
        check("t4_new_pc", bus.ic_pc_o, 32'h100);
        tick();
        check("t4_head_vld", bus.is_vld_o, 1'b1);
        check("t4_head_pc", bus.is_pc_o, 32'h100);

        // Flush beats same-cycle pop (and push).
        do_reset();
        bus.ic_vld_i = 1'b1;
        repeat (4) tick();
        bus.is_rdy_i = 1'b1; bus.br_flag_i = 1'b1; bus.br_cbt_i = 32'h200;
        tick();
        check("t5_cnt", bus.q_cnt_o, 0);
        check("t5_vld", bus.is_vld_o, 1'b0);
        check("t5_pc", bus.ic_pc_o, 32'h200);
        bus.is_rdy_i = 1'b0; bus.br_flag_i = 1'b0;
        repeat (2) tick();
        bus.is_rdy_i = 1'b1; bus.br_flag_i = 1'b1; bus.br_cbt_i = 32'h300;
        tick();
        check("t5b_cnt", bus.q_cnt_o, 0);
        check("t5b_pc", bus.ic_pc_o, 32'h300);

        // Global stall freezes everything.
        do_reset();
        bus.ic_vld_i = 1'b1;
        repeat (2) tick();
        en = 1'b0; bus.is_rdy_i = 1'b1; bus.br_flag_i = 1'b1; bus.br_cbt_i = 32'h400;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_cnt", bus.q_cnt_o, 2);
            check("t6_req", bus.ic_req_o, 1'b0);
            check("t6_head", bus.is_pc_o, 32'h0);
        end
        en = 1'b1; bus.is_rdy_i = 1'b0; bus.br_flag_i = 1'b0;
        tick();
        check("t6_resume_cnt", bus.q_cnt_o, 3);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 199) == 0);
            en             = ($urandom_range(0, 9) != 0);
            bus.ic_vld_i   = ($urandom_range(0, 2) != 0);
            bus.ic_ins_i   = rand_ins();
            bus.bp_br_i    = $urandom_range(0, 1) != 0;
            bus.br_flag_i  = ($urandom_range(0, 15) == 0);
            t = $urandom; t[0] = 1'b0;
            bus.br_cbt_i   = t;
            bus.br_abr_i   = $urandom_range(0, 1) != 0;
            bus.br_tpc_i   = $urandom;
            bus.is_rdy_i   = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
